// File: rtl/plot_port_arbiter.sv
// Round-robin owner of the single VGA plot port; one-hot grant, owner pixels registered once toward the adapter.
// Optional grant watchdog is compiled in with `define PLOT_WATCHDOG_EN (limit set by WDOG_CYCLES).
module plot_port_arbiter #(
    parameter int NREQ        = 6,
    parameter int WDOG_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   done,
    input  logic [8*NREQ-1:0] x_in,
    input  logic [7*NREQ-1:0] y_in,
    input  logic [3*NREQ-1:0] colour_in,
    input  logic [NREQ-1:0]   plot_in,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        owner,
    output logic              busy,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              drop_err,
    output logic              wdog_err
);

    if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 2 || WDOG_CYCLES > 32768) begin : g_bad_params
        $error("plot_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic            busy_q, busy_d;
    logic [7:0]      vga_x_q, vga_x_d;
    logic [6:0]      vga_y_q, vga_y_d;
    logic [2:0]      vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;
    logic            drop_err_q, drop_err_d;

    logic            any_req;
    logic [2:0]      win_idx;
    logic [3:0]      cand;
    logic            owner_plot;
    logic            wdog_fire;
    logic [NREQ-1:0] foreign_plot;

    // Scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        any_req = 1'b0;
        win_idx = 3'd0;
        cand    = 4'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (req[cand[2:0]]) begin
                any_req = 1'b1;
                win_idx = cand[2:0];
            end
        end
    end

    assign owner_plot   = (state_q == GRANT) && plot_in[owner_q];
    assign foreign_plot = (state_q == GRANT) ? (plot_in & ~gnt_q) : plot_in;

`ifdef PLOT_WATCHDOG_EN
    logic [14:0] wcnt_q, wcnt_d;
    logic        wdog_err_q, wdog_err_d;

    always_comb begin
        wdog_fire  = (state_q == GRANT) && !owner_plot && (wcnt_q == 15'(WDOG_CYCLES - 1));
        wdog_err_d = wdog_err_q | wdog_fire;
        wcnt_d     = 15'd0;
        if (state_q == GRANT && !owner_plot) begin
            wcnt_d = wcnt_q + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wcnt_q     <= 15'd0;
            wdog_err_q <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        busy_d       = busy_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        drop_err_d   = drop_err_q | (|foreign_plot);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << win_idx;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                vga_x_d      = x_in[{owner_q, 3'b000} +: 8];
                vga_y_d      = y_in[7*owner_q +: 7];
                vga_colour_d = colour_in[3*owner_q +: 3];
                vga_plot_d   = owner_plot;
                // A final pixel arriving with done still goes out.
                if (done[owner_q] || wdog_fire) begin
                    state_d  = RELEASE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= 3'd0;
            rr_ptr_q     <= 3'd0;
            busy_q       <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Randomized and directed bench for plot_port_arbiter against a cycle-level behavioural model.
module tb_plot_port_arbiter;
    localparam int NREQ = 6;
    localparam int WDOG = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req, done, plot_in;
    logic [8*NREQ-1:0] x_in;
    logic [7*NREQ-1:0] y_in;
    logic [3*NREQ-1:0] colour_in;
    logic [NREQ-1:0]   gnt;
    logic [2:0]        owner;
    logic              busy, vga_plot, drop_err, wdog_err;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;

    plot_port_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .plot_in(plot_in), .gnt(gnt), .owner(owner), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .drop_err(drop_err), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural model: phase 0 = no owner, 1 = owner holds port, 2 = release bubble.
    int          m_phase, m_owner, m_rr, m_wait;
    logic [NREQ-1:0] m_gnt;
    logic        m_busy, m_plot, m_drop, m_wdog;
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic [2:0]  m_c;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_rr = 0; m_wait = 0; m_gnt = '0;
        m_busy = 0; m_plot = 0; m_drop = 0; m_wdog = 0; m_x = 0; m_y = 0; m_c = 0;
    endtask

    task automatic model_update();
        bit fire;
        int w;
        if (!resetn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NREQ; i++)
            if (plot_in[i] && !(m_phase == 1 && i == m_owner)) m_drop = 1;
        m_plot = 0;
        fire   = 0;
        if (m_phase == 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            if (w >= 0) begin
                m_phase = 1; m_owner = w; m_gnt = NREQ'(1 << w); m_busy = 1; m_wait = 0;
            end
        end else if (m_phase == 1) begin
            m_x    = x_in[8*m_owner +: 8];
            m_y    = y_in[7*m_owner +: 7];
            m_c    = colour_in[3*m_owner +: 3];
            m_plot = plot_in[m_owner];
`ifdef PLOT_WATCHDOG_EN
            if (plot_in[m_owner]) m_wait = 0;
            else if (m_wait == WDOG - 1) fire = 1;
            else m_wait++;
`endif
            if (done[m_owner] || fire) begin
                m_phase = 2; m_gnt = '0; m_busy = 0; m_rr = (m_owner + 1) % NREQ;
                if (fire) m_wdog = 1;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("gnt", gnt, m_gnt);
        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        check("vga_plot", vga_plot, m_plot);
        check("vga_x", vga_x, m_x);
        check("vga_y", vga_y, m_y);
        check("vga_colour", vga_colour, m_c);
        check("drop_err", drop_err, m_drop);
        check("wdog_err", wdog_err, m_wdog);
    endtask

    task automatic pulse_done(input int idx);
        done = NREQ'(1 << idx);
        step();
        done = '0;
    endtask

    task automatic wait_grant(input int idx, input int gap_exp);
        int n = 0;
        while (!busy && n < 8) begin
            step();
            n++;
        end
        check("grant_seen", busy, 1'b1);
        check("grant_owner", owner, idx);
        if (gap_exp > 0) check("grant_gap", n, gap_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int order[4] = '{1, 2, 5, 1};
        model_reset();
        resetn = 0; req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        step(); step();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_vga_plot", vga_plot, 0);
        resetn = 1;

        // Single requester, one pixel, release.
        req = 6'b000001;
        step();
        check("t1_gnt", gnt, 6'b000001);
        plot_in = 6'b000001; x_in[7:0] = 8'd10; y_in[6:0] = 7'd20; colour_in[2:0] = 3'b111;
        step();
        plot_in = '0;
        check("t1_plot", vga_plot, 1);
        check("t1_x", vga_x, 10);
        check("t1_y", vga_y, 20);
        check("t1_colour", vga_colour, 7);
        req = '0;
        pulse_done(0);
        check("t1_gnt_low", gnt, 0);

        // Round-robin over held requests, one idle bubble between grants.
        req = 6'b100110;
        foreach (order[i]) begin
            wait_grant(order[i], 2);
            pulse_done(order[i]);
        end

        // Non-owner pixel is dropped and flagged.
        req = 6'b000100;
        wait_grant(2, 2);
        plot_in = 6'b001000; x_in[31:24] = 8'd50;
        step();
        plot_in = '0;
        check("t3_no_plot", vga_plot, 0);
        check("t3_drop", drop_err, 1);
        req = '0;
        pulse_done(2);
        step(); step();
        check("t3_drop_sticky", drop_err, 1);

        // Owner lowering req keeps the grant; pixels keep flowing.
        req = 6'b010000;
        wait_grant(4, 0);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            plot_in = 6'b010000; x_in[39:32] = 8'($urandom);
            step();
            check("t4_gnt", gnt, 6'b010000);
        end
        plot_in = '0;
        pulse_done(4);

        // Reset mid-stream.
        req = 6'b000001;
        wait_grant(0, 0);
        plot_in = 6'b000001;
        step();
        resetn = 0;
        step();
        check("t5_gnt", gnt, 0);
        check("t5_plot", vga_plot, 0);
        check("t5_busy", busy, 0);
        resetn = 1; plot_in = '0; req = 6'b000010;
        step();
        check("t5_regrant", gnt, 6'b000010);

        // Grant with no pixels: watchdog release, or indefinite hold.
        req = '0;
`ifdef PLOT_WATCHDOG_EN
        for (int i = 0; i < 20; i++) step();
        check("t6_wdog_gnt", gnt, 0);
        check("t6_wdog_err", wdog_err, 1);
`else
        for (int i = 0; i < 100; i++) step();
        check("t6_hold_gnt", gnt, 6'b000010);
        check("t6_wdog_err", wdog_err, 0);
        pulse_done(1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            resetn    = ($urandom_range(0, 199) != 0);
            req       = NREQ'($urandom);
            done      = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
            plot_in   = ($urandom_range(0, 9) < 7) ? NREQ'(1 << m_owner) : '0;
            if ($urandom_range(0, 39) == 0) plot_in = plot_in | NREQ'(1 << $urandom_range(0, NREQ - 1));
            x_in      = {$urandom, $urandom};
            y_in      = {$urandom, $urandom};
            colour_in = NREQ*3'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
